// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: bit-level UART transmitter.
// Accepts one byte per valid/ready handshake and shifts it out LSB-first:
// start bit, 8 data bits, optional even parity bit, STOP_BITS stop bits.
// Each serial bit lasts CLK_DIV clka cycles.
// Optional feature macro: UART_TX_PARITY_EN inserts one even-parity bit
// after data bit 7. Without it, DATA goes straight to STOP.

module uart_tx_serializer #(
    parameter int CLK_DIV   = 16,  // clka cycles per serial bit, 2..65535
    parameter int STOP_BITS = 1    // 1 or 2
) (
    input  logic       clka,
    input  logic       reset,      // asynchronous, active-low
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_line,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int               DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t           state;
    logic [7:0]       shift;     // remaining data bits, current bit in [0]
    logic [DIV_W-1:0] div;       // position inside the current serial bit
    logic [2:0]       bit_cnt;   // data bit index 0..7
    logic             stop_cnt;  // stop bit index 0..STOP_BITS-1
    logic             bit_end;   // last clka cycle of the current serial bit
`ifdef UART_TX_PARITY_EN
    logic             par;       // even parity of the byte in flight
`endif

    assign bit_end = (div == DIV_LAST);

    // Ready is a pure state decode so the upstream FSM sees it without a
    // cycle of lag; it never depends on tx_valid.
    assign tx_ready = (state == S_IDLE);

    // Frame sequencer: divider, bit counters, shift register and all
    // registered outputs advance together.
    // NOTE: every register here uses non-blocking assignment so all updates
    // in one edge see the pre-edge values of the others.
    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            shift    <= '0;
            div      <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx_line  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx_line <= 1'b1;
                    if (tx_valid) begin
                        shift    <= tx_data;
                        div      <= '0;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        tx_line  <= 1'b0;
                        tx_busy  <= 1'b1;
                        state    <= S_START;
`ifdef UART_TX_PARITY_EN
                        par      <= ^tx_data;
`endif
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        div     <= '0;
                        tx_line <= shift[0];
                        state   <= S_DATA;
                    end else begin
                        div <= div + 1'b1;
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        div <= '0;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_line <= par;
                            state   <= S_PARITY;
`else
                            tx_line <= 1'b1;
                            state   <= S_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift   <= shift >> 1;
                            // Drive the bit that becomes shift[0] after this shift.
                            tx_line <= shift[1];
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        div     <= '0;
                        tx_line <= 1'b1;
                        state   <= S_STOP;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (bit_end) begin
                        div <= '0;
                        if (stop_cnt == STOP_LAST) begin
                            tx_line <= 1'b1;
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end

                default: begin
                    tx_line <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
